// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcode, ALU, mux-select and state encodings shared by multicycle_control.
package multicycle_pkg;
  localparam logic [3:0] OP_HALT = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_SPLIT = 4'd3,
                         OP_MOD2 = 4'd4, OP_INCR = 4'd5, OP_SET = 4'd6, OP_MUL = 4'd7,
                         OP_LOAD = 4'd8, OP_STORE = 4'd9, OP_BEQ = 4'd10, OP_JUMP = 4'd11,
                         OP_BNE = 4'd12;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_MUL = 3'b010,
                         ALU_SPLIT = 3'b100, ALU_MOD2 = 3'b101, ALU_INCR = 3'b110;
  localparam logic [1:0] PC_PLUS1 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_IMM = 2'b01, WB_MEM = 2'b10;
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MUL_WAIT, ST_WB, ST_HALTED
  } state_e;
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [2:0] alu_op;
    logic       mul_start;
    logic       incr_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       halt;
  } ctrl_t;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: alu_of = ALU_SUB;
      OP_SPLIT:               alu_of = ALU_SPLIT;
      OP_MOD2:                alu_of = ALU_MOD2;
      OP_INCR:                alu_of = ALU_INCR;
      OP_MUL:                 alu_of = ALU_MUL;
      default:                alu_of = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational map of FSM state + registered opcode + ZERO to datapath controls.
module mc_decode
  import multicycle_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] op,
  input  logic       zero,
  output ctrl_t      ctrl
);
  logic ex, wb, jump, taken;
  always_comb begin
    ex = state == ST_EXEC;
    wb = state == ST_WB;
    jump = ex && op == OP_JUMP;
    taken = ex && ((op == OP_BEQ && zero) || (op == OP_BNE && !zero));
    ctrl.ir_write = state == ST_FETCH;
    ctrl.pc_write = state == ST_FETCH || jump || taken;
    ctrl.pc_sel = jump ? PC_JUMP : taken ? PC_BRANCH : PC_PLUS1;
    ctrl.alu_op = (ex || wb) ? alu_of(op) : state == ST_MUL_WAIT ? ALU_MUL : ALU_ADD;
    ctrl.mul_start = ex && op == OP_MUL;
    ctrl.incr_op = (ex || wb) && op == OP_INCR;
    ctrl.mem_read = state == ST_MEM && op == OP_LOAD;
    ctrl.mem_write = state == ST_MEM && op == OP_STORE;
    ctrl.reg_write = wb;
    ctrl.wb_sel = !wb ? WB_ALU : op == OP_SET ? WB_IMM : op == OP_LOAD ? WB_MEM : WB_ALU;
    ctrl.halt = state == ST_HALTED;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with halt/resume,
// multiply watchdog and retired-instruction counter.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MUL_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                ZERO,
  input  logic                MUL_DONE,
  input  logic                MEM_READY,
  input  logic                RESUME,
  output logic                IR_WRITE,
  output logic                PC_WRITE,
  output logic [1:0]          PC_SEL,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                MUL_START,
  output logic                INCR_OP,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic                REG_WRITE,
  output logic [1:0]          WB_SEL,
  output logic                HALT,
  output logic                FAULT,
  output logic                ILLEGAL,
  output logic [CNT_W-1:0]    RETIRED
);
  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [7:0]          wd_q, wd_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire, illegal, is_halt;
  logic [3:0]          op4;
  ctrl_t               c, g;
  assign op4 = op_q[3:0];
  assign is_halt = OPCODE == '0;
  assign illegal = state_q == ST_DECODE && OPCODE > OPCODE_W'(OP_BNE);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    fault_d = fault_q;
    retire = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = OPCODE;
        state_d = is_halt ? ST_HALTED : illegal ? ST_FETCH : ST_EXEC;
        retire = is_halt;
      end
      ST_EXEC: begin
        state_d = op4 == OP_MUL ? ST_MUL_WAIT
                : op4 inside {OP_LOAD, OP_STORE} ? ST_MEM
                : op4 inside {OP_BEQ, OP_BNE, OP_JUMP} ? ST_FETCH : ST_WB;
        retire = op4 inside {OP_BEQ, OP_BNE, OP_JUMP};
      end
      ST_MUL_WAIT: begin
        // A late MUL_DONE on the timeout cycle still completes the multiply.
        if (MUL_DONE) state_d = ST_WB;
        else if (wd_q + 8'd1 == 8'(MUL_TIMEOUT)) begin
          state_d = ST_HALTED;
          fault_d = 1'b1;
        end
      end
      ST_MEM: if (MEM_READY) begin
        state_d = op4 == OP_LOAD ? ST_WB : ST_FETCH;
        retire = op4 == OP_STORE;
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire = 1'b1;
      end
      ST_HALTED: if (RESUME) begin
        state_d = ST_FETCH;
        fault_d = 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase
    wd_d = (state_q == ST_MUL_WAIT && state_d == ST_MUL_WAIT) ? wd_q + 8'd1 : 8'd0;
    retired_d = retired_q + CNT_W'(retire);
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_FETCH;
      op_q <= '0;
      wd_q <= '0;
      fault_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      wd_q <= wd_d;
      fault_q <= fault_d;
      retired_q <= retired_d;
    end
  end
  mc_decode u_decode (.state(state_q), .op(op4), .zero(ZERO), .ctrl(c));
  // Every output is forced low while reset is held, regardless of state.
  assign g = RESET_N ? c : '0;
  assign IR_WRITE = g.ir_write;
  assign PC_WRITE = g.pc_write;
  assign PC_SEL = g.pc_sel;
  assign ALU_OP = ALU_OP_W'(g.alu_op);
  assign MUL_START = g.mul_start;
  assign INCR_OP = g.incr_op;
  assign MEM_READ = g.mem_read;
  assign MEM_WRITE = g.mem_write;
  assign REG_WRITE = g.reg_write;
  assign WB_SEL = g.wb_sel;
  assign HALT = g.halt;
  assign FAULT = RESET_N && fault_q;
  assign ILLEGAL = RESET_N && illegal;
  assign RETIRED = RESET_N ? retired_q : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction expected-waveform model driven by directed and random programs.
module tb_multicycle_control;
  localparam int CW = 4;
  localparam int TO = 15;
  localparam int OP_HALT = 0, OP_ADD = 1, OP_SUB = 2, OP_SPLIT = 3, OP_MOD2 = 4, OP_INCR = 5,
                 OP_SET = 6, OP_MUL = 7, OP_LOAD = 8, OP_STORE = 9, OP_BEQ = 10,
                 OP_JUMP = 11, OP_BNE = 12;
  typedef struct packed {
    logic ir, pcw;
    logic [1:0] pcsel;
    logic [2:0] alu;
    logic ms, inc, mr, mw, rw;
    logic [1:0] wbs;
    logic halt, fault, ill;
  } ov_t;
  logic CLK = 1'b0;
  logic RESET_N, ZERO, MUL_DONE, MEM_READY, RESUME;
  logic [3:0] OPCODE;
  logic IR_WRITE, PC_WRITE, MUL_START, INCR_OP, MEM_READ, MEM_WRITE, REG_WRITE, HALT, FAULT, ILLEGAL;
  logic [1:0] PC_SEL, WB_SEL;
  logic [2:0] ALU_OP;
  logic [CW-1:0] RETIRED;
  ov_t outs;
  logic [CW-1:0] ret_m;
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  multicycle_control #(.OPCODE_W(4), .ALU_OP_W(3), .MUL_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .OPCODE(OPCODE), .ZERO(ZERO), .MUL_DONE(MUL_DONE),
    .MEM_READY(MEM_READY), .RESUME(RESUME), .IR_WRITE(IR_WRITE), .PC_WRITE(PC_WRITE),
    .PC_SEL(PC_SEL), .ALU_OP(ALU_OP), .MUL_START(MUL_START), .INCR_OP(INCR_OP),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL),
    .HALT(HALT), .FAULT(FAULT), .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );
  assign outs = {IR_WRITE, PC_WRITE, PC_SEL, ALU_OP, MUL_START, INCR_OP, MEM_READ, MEM_WRITE,
                 REG_WRITE, WB_SEL, HALT, FAULT, ILLEGAL};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int alu_of(input int op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return 1;
      OP_SPLIT: return 4;
      OP_MOD2: return 5;
      OP_INCR: return 6;
      OP_MUL: return 2;
      default: return 0;
    endcase
  endfunction
  // Called with inputs already set for this cycle; checks, then moves to the next cycle.
  task automatic cyc(input string tag, input ov_t e);
    #1;
    check(tag, 32'(outs), 32'(e));
    check({tag, "_retired"}, 32'(RETIRED), 32'(ret_m));
    @(posedge CLK);
    #1;
  endtask
  task automatic halted(input int hold, input bit f);
    ov_t e;
    e = '0;
    e.halt = 1'b1;
    e.fault = f;
    MUL_DONE = 1'b0;
    RESUME = 1'b0;
    repeat (hold) cyc("halted", e);
    RESUME = 1'b1;
    cyc("resume", e);
    RESUME = 1'b0;
  endtask
  task automatic run(input int op, input bit z, input int w, input int hold);
    ov_t e;
    MUL_DONE = 1'b0;
    MEM_READY = 1'b0;
    RESUME = 1'b0;
    OPCODE = 4'($urandom);
    ZERO = 1'($urandom);
    e = '0; e.ir = 1'b1; e.pcw = 1'b1;
    cyc("fetch", e);
    OPCODE = 4'(op);
    e = '0; e.ill = op >= 13;
    cyc("decode", e);
    if (op >= 13) return;
    if (op == OP_HALT) begin
      ret_m++;
      halted(hold, 1'b0);
      return;
    end
    ZERO = z;
    e = '0;
    e.alu = 3'(alu_of(op));
    e.inc = op == OP_INCR;
    e.ms = op == OP_MUL;
    if (op == OP_JUMP) begin e.pcw = 1'b1; e.pcsel = 2'd2; end
    if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) begin e.pcw = 1'b1; e.pcsel = 2'd1; end
    cyc("exec", e);
    ZERO = 1'($urandom);
    if (op == OP_BEQ || op == OP_BNE || op == OP_JUMP) begin
      ret_m++;
      return;
    end
    if (op == OP_MUL) begin
      for (int k = 0; k < TO; k++) begin
        MUL_DONE = k == w;
        e = '0; e.alu = 3'd2;
        cyc("mul_wait", e);
        if (k == w) break;
      end
      MUL_DONE = 1'b0;
      if (w >= TO) begin
        halted(hold, 1'b1);
        return;
      end
    end
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int k = 0; k <= w; k++) begin
        MEM_READY = k == w;
        e = '0; e.mr = op == OP_LOAD; e.mw = op == OP_STORE;
        cyc("mem", e);
      end
      MEM_READY = 1'b0;
      if (op == OP_STORE) begin
        ret_m++;
        return;
      end
    end
    e = '0;
    e.rw = 1'b1;
    e.wbs = op == OP_SET ? 2'd1 : op == OP_LOAD ? 2'd2 : 2'd0;
    e.alu = 3'(alu_of(op));
    e.inc = op == OP_INCR;
    cyc("wb", e);
    ret_m++;
  endtask
  initial begin
    ov_t e;
    int op, r, w;
    RESET_N = 1'b0; OPCODE = '0; ZERO = 1'b0; MUL_DONE = 1'b0; MEM_READY = 1'b0; RESUME = 1'b0;
    ret_m = '0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      check("reset_outs", 32'(outs), 32'd0);
      check("reset_retired", 32'(RETIRED), 32'd0);
    end
    RESET_N = 1'b1;
    run(OP_ADD, 1'b0, 0, 0);
    run(OP_LOAD, 1'b0, 2, 0);
    run(OP_STORE, 1'b0, 0, 0);
    run(OP_BEQ, 1'b1, 0, 0);
    run(OP_BNE, 1'b1, 0, 0);
    run(OP_BNE, 1'b0, 0, 0);
    run(OP_JUMP, 1'b0, 0, 0);
    run(OP_MUL, 1'b0, 4, 0);
    run(OP_MUL, 1'b0, 14, 0);
    run(OP_MUL, 1'b0, 40, 2);
    run(OP_HALT, 1'b0, 0, 10);
    run(14, 1'b0, 0, 0);
    run(OP_SET, 1'b0, 0, 0);
    run(OP_INCR, 1'b0, 0, 0);
    repeat (16) run(OP_ADD, 1'b0, 0, 0);
    e = '0; e.ir = 1'b1; e.pcw = 1'b1;
    cyc("rs_fetch", e);
    OPCODE = 4'(OP_STORE);
    e = '0;
    cyc("rs_decode", e);
    cyc("rs_exec", e);
    MEM_READY = 1'b0;
    e.mw = 1'b1;
    cyc("rs_mem", e);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    ret_m = '0;
    e = '0;
    cyc("rs_held", e);
    RESET_N = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 15);
      if (op == OP_MUL) begin
        r = $urandom_range(0, 9);
        w = r < 7 ? r : r == 7 ? TO - 1 : TO + $urandom_range(0, 3);
      end else w = $urandom_range(0, 3);
      run(op, 1'($urandom), w, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder of the 10-bit ISA core.
- Sequences every instruction through FETCH / DECODE / EXEC / MEM / WB states.
- Waits on handshakes from the multiplier and data memory, and resolves branches from the ALU zero flag.
- Provides a resumable HALT state, a multiply watchdog and a retired-instruction counter. It sits between the IR and the datapath muxes, register file and memories.

Parameters:
- OPCODE_W, 4, opcode field width; encodings live in the shared package and occupy the low 4 bits.
- ALU_OP_W, 3, ALU operation code width.
- MUL_TIMEOUT, 15, max MUL_WAIT cycles before a fault is raised; range 1..255.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  synchronous active-low reset.
- OPCODE  in  OPCODE_W  opcode from IR; valid from DECODE onward.
- ZERO  in  1  ALU result == 0.
- MUL_DONE  in  1  multiplier result valid.
- MEM_READY  in  1  data memory completed the access.
- RESUME  in  1  leave HALTED.
- IR_WRITE  out  1  latch instruction.
- PC_WRITE  out  1  update PC.
- PC_SEL  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- ALU_OP  out  ALU_OP_W  ALU operation.
- MUL_START  out  1  one-cycle multiplier start.
- INCR_OP  out  1  increment mode.
- MEM_READ  out  1  data read request.
- MEM_WRITE  out  1  data write request.
- REG_WRITE  out  1  register file write.
- WB_SEL  out  2  00 = ALU, 01 = immediate, 10 = memory.
- HALT  out  1  core halted.
- FAULT  out  1  sticky multiply-timeout flag.
- ILLEGAL  out  1  one-cycle pulse on an unsupported opcode.
- RETIRED  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: RESET_N low at a CLK edge forces the following.
  - State = FETCH; OP_Q = 0; watchdog = 0; FAULT = 0; RETIRED = 0.
  - All other outputs are 0 while RESET_N is low.
  - Reset mid-instruction abandons the instruction with no write.
- Outputs are Moore: decoded from the current state plus OP_Q (opcode registered in DECODE).
- Unlisted outputs are 0 in each state.
- FETCH (1 cycle): IR_WRITE = 1, PC_WRITE = 1, PC_SEL = 00; next state DECODE.
- DECODE (1 cycle): capture OP_Q = OPCODE.
  - 0000 goes to HALTED.
  - Opcodes 1101–1111 pulse ILLEGAL and go to FETCH; they are not retired.
  - All other opcodes go to EXEC.
- EXEC actions by opcode:
  - ADD: ALU_OP = 000, go to WB.
  - SUB: ALU_OP = 001, go to WB.
  - SPLIT: ALU_OP = 100, go to WB.
  - MOD2: ALU_OP = 101, go to WB.
  - INCR: ALU_OP = 110 and INCR_OP = 1, go to WB.
  - SET: go to WB.
  - MUL: ALU_OP = 010 and MUL_START = 1, go to MUL_WAIT.
  - LOAD / STORE: go to MEM.
  - BEQ / BNE: ALU_OP = 001. The branch is taken when (BEQ and ZERO) or (BNE and not ZERO); taken asserts PC_WRITE = 1 with PC_SEL = 01. Go to FETCH and retire.
  - JUMP: PC_WRITE = 1, PC_SEL = 10; go to FETCH and retire.
- MUL_WAIT: ALU_OP = 010 is held and the watchdog increments each cycle.
  - MUL_DONE = 1 goes to WB.
  - If the watchdog reaches MUL_TIMEOUT with MUL_DONE low, set FAULT and go to HALTED with no write and no retire.
  - If MUL_DONE arrives on the same cycle the watchdog reaches MUL_TIMEOUT, MUL_DONE wins.
  - The watchdog clears on leaving MUL_WAIT.
- MEM: LOAD holds MEM_READ = 1; STORE holds MEM_WRITE = 1, until MEM_READY = 1.
  - LOAD then goes to WB.
  - STORE then goes to FETCH and retires.
  - Zero wait is allowed: MEM_READY high on the first MEM cycle completes in 1 cycle.
- WB (1 cycle): REG_WRITE = 1.
  - WB_SEL = 01 for SET, 10 for LOAD, 00 otherwise.
  - ALU_OP and INCR_OP are held from EXEC.
  - Retire, then go to FETCH.
- HALTED: HALT = 1.
  - RESUME = 1 goes to FETCH and clears FAULT.
  - The HALT opcode itself counts as retired on entry to HALTED; a timeout entry does not.
- Retire: RETIRED increments by 1 on the transition; it wraps from 2^CNT_W−1 to 0.
- Latencies in cycles:
  - ADD, SUB, SPLIT, MOD2, INCR, SET: 4.
  - Branch, JUMP: 3.
  - LOAD: 5 + memory wait.
  - STORE: 4 + memory wait.
  - MUL: 5 + multiply wait.

Decomposition:
- Package multicycle_pkg holds:
  - opcode localparams (HALT = 0000 … BNE = 1100);
  - ALU op codes;
  - WB_SEL and PC_SEL codes;
  - the state encoding (FETCH, DECODE, EXEC, MEM, MUL_WAIT, WB, HALTED).
- Sub-module mc_decode: purely combinational mapping of state + OP_Q + ZERO to control outputs. The FSM, watchdog and counter stay in the top module.

Test Plan:
- Reset 3 cycles, then ADD (0001) → IR_WRITE at cycle 0, REG_WRITE with WB_SEL = 00 and ALU_OP = 000 at cycle 3, RETIRED = 1 at cycle 4.
- LOAD with MEM_READY low for 2 cycles → MEM_READ high for 3 cycles, then WB with WB_SEL = 10; STORE with MEM_READY already high → MEM_WRITE for exactly 1 cycle and no REG_WRITE.
- BEQ with ZERO = 1 → PC_WRITE = 1, PC_SEL = 01; BNE with ZERO = 1 → PC_WRITE = 0; JUMP → PC_SEL = 10; each retires once.
- MUL with MUL_DONE after 4 cycles → MUL_START a single pulse, then REG_WRITE; MUL with MUL_TIMEOUT = 15 and MUL_DONE never high → FAULT = 1 and HALT = 1 after 15 MUL_WAIT cycles, RETIRED unchanged.
- HALT opcode → HALT held for 10 cycles with no PC_WRITE; RESUME → FETCH next cycle with FAULT = 0; opcode 1110 → ILLEGAL single pulse, RETIRED unchanged.
- RESET_N low during MEM of a STORE → MEM_WRITE = 0 the next cycle and RETIRED = 0; with CNT_W = 4, 16 ADDs → RETIRED wraps from 15 to 0.
